// File: rtl/cic_interpolator_if.sv
// cic_interpolator_if: low-rate sample handshake plus high-rate sample/strobe/underrun outputs
interface cic_interpolator_if #(
  parameter int INP_WIDTH = 16,
  parameter int OUT_WIDTH = 25
);
  logic [INP_WIDTH-1:0] s_data;
  logic s_valid;
  logic s_ready;
  logic [OUT_WIDTH-1:0] samp_out_data;
  logic samp_out_str;
  logic underrun;
  modport master (
    output s_data, s_valid,
    input s_ready, samp_out_data, samp_out_str, underrun
  );
  modport slave (
    input s_data, s_valid,
    output s_ready, samp_out_data, samp_out_str, underrun
  );
endinterface

// File: rtl/cic_interpolator.sv
// cic_interpolator: N-stage CIC interpolator by R with zero-stuffing and input-starvation detect
module cic_interpolator #(
  parameter int INP_WIDTH = 16,
  parameter int CIC_R = 8,
  parameter int CIC_N = 3,
  parameter int CIC_M = 1,
  parameter int OUT_WIDTH = INP_WIDTH + CIC_N * $clog2(CIC_R * CIC_M)
) (
  input logic clk,
  input logic reset_n,
  cic_interpolator_if.slave bus
);
  localparam int W = INP_WIDTH + CIC_N * $clog2(CIC_R * CIC_M);
  localparam int PW = $clog2(CIC_R);
  logic [PW-1:0] phase;
  logic accept, adv, started, str, ur;
  logic [W-1:0] acc, stuffed;
  logic [W-1:0] cin [CIC_N];
  logic [W-1:0] dly [CIC_N][CIC_M];
  logic [W-1:0] integ [CIC_N];
  assign bus.s_ready = phase == '0;
  assign accept = bus.s_valid && bus.s_ready;
  assign adv = phase != '0 || accept;
  assign stuffed = accept ? acc : '0;
  assign bus.samp_out_data = integ[CIC_N-1][W-1 -: OUT_WIDTH];
  assign bus.samp_out_str = str;
  assign bus.underrun = ur;
  // comb chain runs in the accept cycle; cin[k] is what stage k pushes into its delay line
  always_comb begin
    acc = {{(W-INP_WIDTH){bus.s_data[INP_WIDTH-1]}}, bus.s_data};
    for (int k = 0; k < CIC_N; k++) begin
      cin[k] = acc;
      acc = acc - dly[k][CIC_M-1];
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      phase <= '0;
      started <= 1'b0;
      str <= 1'b0;
      ur <= 1'b0;
      for (int k = 0; k < CIC_N; k++) begin
        integ[k] <= '0;
        for (int j = 0; j < CIC_M; j++) dly[k][j] <= '0;
      end
    end else begin
      str <= adv;
      ur <= started && bus.s_ready && !bus.s_valid;
      if (accept) started <= 1'b1;
      if (adv) phase <= phase == PW'(CIC_R - 1) ? '0 : phase + 1'b1;
      if (accept)
        for (int k = 0; k < CIC_N; k++) begin
          dly[k][0] <= cin[k];
          for (int j = 1; j < CIC_M; j++) dly[k][j] <= dly[k][j-1];
        end
      if (adv) begin
        integ[0] <= integ[0] + stuffed;
        for (int k = 1; k < CIC_N; k++) integ[k] <= integ[k] + integ[k-1];
      end
    end
endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: four CIC configurations checked against an impulse-response convolution model
module tb_cic_interpolator;
  localparam int WA = 16 + 3 * $clog2(8);
  localparam int WB = 16 + 3 * $clog2(16);
  localparam int WC = 16 + 1 * $clog2(4);
  localparam int WD = 16 + 3 * $clog2(4);
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  cic_interpolator_if #(.INP_WIDTH(16), .OUT_WIDTH(WA)) ia();
  cic_interpolator_if #(.INP_WIDTH(16), .OUT_WIDTH(WB - 4)) ib();
  cic_interpolator_if #(.INP_WIDTH(16), .OUT_WIDTH(WC)) ic();
  cic_interpolator_if #(.INP_WIDTH(16), .OUT_WIDTH(WD)) id();
  cic_interpolator #(.INP_WIDTH(16), .CIC_R(8), .CIC_N(3), .CIC_M(1), .OUT_WIDTH(WA))
    ua (.clk(clk), .reset_n(reset_n), .bus(ia));
  cic_interpolator #(.INP_WIDTH(16), .CIC_R(8), .CIC_N(3), .CIC_M(2), .OUT_WIDTH(WB - 4))
    ub (.clk(clk), .reset_n(reset_n), .bus(ib));
  cic_interpolator #(.INP_WIDTH(16), .CIC_R(4), .CIC_N(1), .CIC_M(1), .OUT_WIDTH(WC))
    uc (.clk(clk), .reset_n(reset_n), .bus(ic));
  cic_interpolator #(.INP_WIDTH(16), .CIC_R(4), .CIC_N(3), .CIC_M(1), .OUT_WIDTH(WD))
    ud (.clk(clk), .reset_n(reset_n), .bus(id));
  int n_cmp = 0;
  int n_err = 0;
  int ns_c [4] = '{3, 3, 1, 3};
  int rr_c [4] = '{8, 8, 4, 4};
  int m_c [4] = '{1, 2, 1, 1};
  int w_c [4] = '{WA, WB, WC, WD};
  int rr_s [2] = '{8, 4};
  string nm [4] = '{"a", "b", "c", "d"};
  longint h [4][64];
  int hn [4];
  longint u [4][8192];
  int nu [4];
  int ph [2];
  bit st [2], ur_e [2], se [2];
  longint qa [$], qb [$], qc [$], qd [$];
  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // impulse response of the whole interpolator at the high rate: N-fold box of length R*M
  task automatic build_h();
    for (int i = 0; i < 4; i++) begin
      hn[i] = 1;
      h[i][0] = 1;
      for (int s = 0; s < ns_c[i]; s++) begin
        longint t [64];
        int l;
        l = hn[i] + rr_c[i] * m_c[i] - 1;
        for (int x = 0; x < 64; x++) t[x] = 0;
        for (int a = 0; a < hn[i]; a++)
          for (int b = 0; b < rr_c[i] * m_c[i]; b++) t[a+b] += h[i][a];
        for (int x = 0; x < l; x++) h[i][x] = t[x];
        hn[i] = l;
      end
    end
  endtask
  // strobe n shows the convolution delayed by the N-1 integrator registers, wrapped to W bits
  function automatic longint model_y(input int i, input int n);
    longint y;
    y = 0;
    for (int k = 0; k < hn[i]; k++) begin
      int j;
      j = n - (ns_c[i] - 1) - k;
      if (j >= 0) y += h[i][k] * u[i][j];
    end
    y = (y << (64 - w_c[i])) >>> (64 - w_c[i]);
    return y;
  endfunction
  task automatic step(input bit va, input bit vb, input logic [15:0] d0, d1, d2, d3);
    logic [15:0] dd [4];
    bit vv [2], acc [2];
    logic rdy [4], so [4], un [4];
    longint y;
    dd = '{d0, d1, d2, d3};
    vv = '{va, vb};
    @(negedge clk);
    rdy = '{ia.s_ready, ib.s_ready, ic.s_ready, id.s_ready};
    so = '{ia.samp_out_str, ib.samp_out_str, ic.samp_out_str, id.samp_out_str};
    un = '{ia.underrun, ib.underrun, ic.underrun, id.underrun};
    for (int i = 0; i < 4; i++) begin
      chk({nm[i], "_ready"}, longint'(rdy[i]), longint'(ph[i/2] == 0));
      chk({nm[i], "_strobe"}, longint'(so[i]), longint'(se[i/2]));
      chk({nm[i], "_underrun"}, longint'(un[i]), longint'(ur_e[i/2]));
    end
    ia.s_valid = va; ib.s_valid = va; ic.s_valid = vb; id.s_valid = vb;
    ia.s_data = d0; ib.s_data = d1; ic.s_data = d2; id.s_data = d3;
    for (int s = 0; s < 2; s++) begin
      acc[s] = vv[s] && ph[s] == 0;
      ur_e[s] = st[s] && ph[s] == 0 && !vv[s];
      se[s] = ph[s] != 0 || acc[s];
      st[s] = st[s] | acc[s];
      if (se[s]) ph[s] = (ph[s] + 1) % rr_s[s];
    end
    for (int i = 0; i < 4; i++)
      if (se[i/2] && nu[i] < 8192) begin
        u[i][nu[i]] = acc[i/2] ? longint'($signed(dd[i])) : 0;
        y = model_y(i, nu[i]);
        nu[i]++;
        case (i)
          0: qa.push_back(y);
          1: qb.push_back(y >>> 4);
          2: qc.push_back(y);
          default: qd.push_back(y);
        endcase
      end
  endtask
  task automatic do_reset(input int cyc);
    logic rdy [4], so [4], un [4];
    @(negedge clk);
    #2 reset_n = 1'b0;
    ia.s_valid = 0; ib.s_valid = 0; ic.s_valid = 0; id.s_valid = 0;
    ia.s_data = 0; ib.s_data = 0; ic.s_data = 0; id.s_data = 0;
    ph = '{0, 0}; st = '{0, 0}; ur_e = '{0, 0}; se = '{0, 0}; nu = '{0, 0, 0, 0};
    qa.delete(); qb.delete(); qc.delete(); qd.delete();
    #1;
    repeat (cyc) @(negedge clk);
    rdy = '{ia.s_ready, ib.s_ready, ic.s_ready, id.s_ready};
    so = '{ia.samp_out_str, ib.samp_out_str, ic.samp_out_str, id.samp_out_str};
    un = '{ia.underrun, ib.underrun, ic.underrun, id.underrun};
    for (int i = 0; i < 4; i++) begin
      chk({nm[i], "_rst_ready"}, longint'(rdy[i]), 1);
      chk({nm[i], "_rst_strobe"}, longint'(so[i]), 0);
      chk({nm[i], "_rst_underrun"}, longint'(un[i]), 0);
    end
    chk("a_rst_data", longint'(ia.samp_out_data), 0);
    chk("b_rst_data", longint'(ib.samp_out_data), 0);
    chk("c_rst_data", longint'(ic.samp_out_data), 0);
    chk("d_rst_data", longint'(id.samp_out_data), 0);
    #2 reset_n = 1'b1;
  endtask
  always @(negedge clk)
    if (ia.samp_out_str) begin
      if (qa.size() == 0) chk("a_spurious_strobe", 1, 0);
      else chk("a_data", longint'($signed(ia.samp_out_data)), qa.pop_front());
      chk("a_known", longint'($isunknown(ia.samp_out_data)), 0);
    end
  always @(negedge clk)
    if (ib.samp_out_str) begin
      if (qb.size() == 0) chk("b_spurious_strobe", 1, 0);
      else chk("b_data", longint'($signed(ib.samp_out_data)), qb.pop_front());
    end
  always @(negedge clk)
    if (ic.samp_out_str) begin
      if (qc.size() == 0) chk("c_spurious_strobe", 1, 0);
      else chk("c_data", longint'($signed(ic.samp_out_data)), qc.pop_front());
    end
  always @(negedge clk)
    if (id.samp_out_str) begin
      if (qd.size() == 0) chk("d_spurious_strobe", 1, 0);
      else chk("d_data", longint'($signed(id.samp_out_data)), qd.pop_front());
    end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bit a, tog;
    int cnt;
    logic [15:0] fs;
    ia.s_valid = 0; ib.s_valid = 0; ic.s_valid = 0; id.s_valid = 0;
    ia.s_data = 0; ib.s_data = 0; ic.s_data = 0; id.s_data = 0;
    build_h();
    do_reset(3);
    // c sees a single unit impulse, d a unit step, a/b random with garbage between phases
    for (int t = 0; t < 120; t++)
      step(1, 1, 16'($urandom()), 16'($urandom()), st[1] ? 16'd0 : 16'd1, 16'd1);
    chk("d_settled", longint'($signed(id.samp_out_data)), 16);
    chk("c_after_impulse", longint'($signed(ic.samp_out_data)), 0);
    for (int t = 0; t < 300; t++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()));
    for (int t = 0; t < 8 && ph[0] != 0; t++)
      step(0, 1, 16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()));
    for (int t = 0; t < 5; t++)
      step(0, 1, 16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()));
    for (int t = 0; t < 40; t++)
      step(1, 1, 16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()));
    for (int t = 0; t < 16 && ph[0] != 5; t++)
      step(1, 1, 16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()));
    do_reset(2);
    for (int t = 0; t < 20; t++)
      step(1, 1, 16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()));
    tog = 0;
    cnt = 0;
    for (int t = 0; t < 4000 && cnt < 200; t++) begin
      a = ph[0] == 0;
      fs = tog ? 16'h8000 : 16'h7fff;
      step(1, 1, fs, fs, 16'($urandom()), 16'($urandom()));
      if (a) begin
        tog = !tog;
        cnt++;
      end
    end
    for (int t = 0; t < 12; t++) step(0, 0, 16'd0, 16'd0, 16'd0, 16'd0);
    chk("a_drained", longint'(qa.size()), 0);
    chk("b_drained", longint'(qb.size()), 0);
    chk("c_drained", longint'(qc.size()), 0);
    chk("d_drained", longint'(qd.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
